// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler
//
// Detects falling edges on N_CH status lines, holds one pending event per
// channel, and issues events one at a time on a shared output port chosen by
// round-robin arbitration. Each issued event carries the channel's wrap-around
// event count (including the event being issued).
//
// Handshake: an event transfers on any posedge where out_valid & out_ready.
// Once out_valid is high, out_ch/out_count stay stable until that transfer.
// out_valid does not wait for out_ready.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   sig_in     monitored lines, one per channel, synchronous to clk
//   out_ready  consumer accepts the presented event
//   out_valid  event presented on out_ch/out_count
//   out_ch     channel index of the presented event
//   out_count  that channel's event count including this event
//   pending    per-channel event waiting to be issued
//   dropped    sticky per-channel flag: an event was lost
module edge_event_scheduler #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sig_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [CNT_W-1:0] out_count,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  dropped
);

  logic [N_CH-1:0]  sig_d;
  logic [N_CH-1:0]  fall;
  logic [CH_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt [N_CH];

  logic             load;
  logic [CH_W-1:0]  winner;
  logic             found;
  logic [CNT_W-1:0] new_cnt;
  logic [CH_W-1:0]  next_ptr;
  int               idx;

  assign fall = sig_d & ~sig_in;

  // The output register may take a new event when it is empty or when the
  // current one is being accepted this cycle.
  assign load = (~out_valid | out_ready) & (|pending);

  // Round-robin search starting at rr_ptr, wrapping modulo N_CH.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!found && pending[idx]) begin
        winner = CH_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign new_cnt  = cnt[winner] + 1'b1;
  assign next_ptr = (winner == CH_W'(N_CH - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d     <= '0;
      pending   <= '0;
      dropped   <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_count <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      sig_d <= sig_in;

      for (int i = 0; i < N_CH; i++) begin
        if (load && (winner == CH_W'(i))) begin
          // Being issued now; a simultaneous new edge re-queues the channel.
          pending[i] <= fall[i];
        end else if (fall[i]) begin
          if (pending[i]) dropped[i] <= 1'b1;
          pending[i] <= 1'b1;
        end
      end

      if (load) begin
        out_valid   <= 1'b1;
        out_ch      <= winner;
        out_count   <= new_cnt;
        cnt[winner] <= new_cnt;
        rr_ptr      <= next_ptr;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
module tb_edge_event_scheduler;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;
  localparam int EW    = CH_W + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  sig_in;
  logic             out_ready;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [CNT_W-1:0] out_count;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  dropped;

  int n_chk  = 0;
  int n_fail = 0;

  logic [EW-1:0] exp_q[$];

  edge_event_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_ch(out_ch), .out_count(out_count),
    .pending(pending), .dropped(dropped)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N_CH-1:0] s);
    rst    = 1'b1;
    sig_in = s;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver helpers
  task automatic push_ev(input int ch, input int count);
    exp_q.push_back({CH_W'(ch), CNT_W'(count)});
  endtask

  task automatic pulse(input logic [N_CH-1:0] m);
    sig_in = sig_in | m;
    tick();
    sig_in = sig_in & ~m;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor: compares every accepted event against the queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected event: ch=%0d count=%0d, expected none", out_ch, out_count);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_ch, out_count} !== e) begin
          n_fail++;
          $display("FAIL event: ch=%0d count=%0d expected ch=%0d count=%0d",
                   out_ch, out_count, e[EW-1:CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    sig_in    = '0;
    rst       = 1'b1;

    // 1: single event on ch2
    do_reset(4'b0000);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset pending", 32'(pending), 0);
    chk("reset dropped", 32'(dropped), 0);
    chk("reset out_count", 32'(out_count), 0);
    push_ev(2, 1);
    pulse(4'b0100);
    chk("t1 pending", 32'(pending), 32'h4);
    drain("t1");
    tick();
    chk("t1 pending after", 32'(pending), 0);
    chk("t1 dropped after", 32'(dropped), 0);
    chk("t1 out_valid after", 32'(out_valid), 0);

    // 2: all four fall together, issued 0,1,2,3
    do_reset(4'b1111);
    tick();
    push_ev(0, 1); push_ev(1, 1); push_ev(2, 1); push_ev(3, 1);
    sig_in = 4'b0000;
    tick();
    chk("t2 pending", 32'(pending), 32'hf);
    drain("t2");
    chk("t2 rr_ptr", 32'(dut.rr_ptr), 0);
    chk("t2 dropped", 32'(dropped), 0);

    // 3: stall with extra edges on ch1
    do_reset(4'b0000);
    out_ready = 1'b0;
    push_ev(1, 1); push_ev(1, 2);
    pulse(4'b0010);
    tick();
    chk("t3 out_valid", 32'(out_valid), 1);
    chk("t3 out_ch", 32'(out_ch), 1);
    chk("t3 out_count", 32'(out_count), 1);
    pulse(4'b0010);
    chk("t3 pending1", 32'(pending), 32'h2);
    chk("t3 dropped after 1st", 32'(dropped), 0);
    chk("t3 held ch", 32'(out_ch), 1);
    chk("t3 held count", 32'(out_count), 1);
    pulse(4'b0010);
    chk("t3 dropped after 2nd", 32'(dropped), 32'h2);
    chk("t3 held valid", 32'(out_valid), 1);
    chk("t3 held count 2", 32'(out_count), 1);
    out_ready = 1'b1;
    drain("t3");
    chk("t3 dropped sticky", 32'(dropped), 32'h2);

    // 4: counter wrap on ch3, other counters untouched
    do_reset(4'b0000);
    for (int i = 0; i < 256; i++) begin
      push_ev(3, (i + 1) % 256);
      pulse(4'b1000);
    end
    drain("t4 wrap");
    push_ev(0, 1);
    pulse(4'b0001);
    drain("t4 ch0");
    chk("t4 dropped", 32'(dropped), 0);

    // 5: fairness with ch0/ch1 re-toggling
    do_reset(4'b0000);
    for (int k = 1; k <= 4; k++) begin
      push_ev(0, k);
      push_ev(1, k);
    end
    for (int k = 0; k < 4; k++) pulse(4'b0011);
    drain("t5");
    chk("t5 dropped", 32'(dropped), 0);

    // 6: reset while stalled with pending work
    do_reset(4'b0000);
    out_ready = 1'b0;
    pulse(4'b0001);
    tick();
    pulse(4'b1010);
    chk("t6 pre out_valid", 32'(out_valid), 1);
    chk("t6 pre pending", 32'(pending), 32'ha);
    rst = 1'b1;
    tick();
    chk("t6 out_valid", 32'(out_valid), 0);
    chk("t6 pending", 32'(pending), 0);
    chk("t6 dropped", 32'(dropped), 0);
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    push_ev(1, 1);
    pulse(4'b0010);
    drain("t6");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Watches N_CH single-bit status lines and detects high-to-low (falling) transitions on each.
- Queues one pending event per channel and shares a single output event port between the channels using round-robin arbitration.
- Keeps a wrap-around event count per channel and reports it with each issued event.
- Sits between raw control/status lines and a downstream consumer that accepts one event at a time over a valid/ready handshake.

Parameters:
- N_CH, 4, number of monitored channels (2..16).
- CNT_W, 8, width of each per-channel event counter.
- CH_W, $clog2(N_CH), width of the channel index (derived; not overridden).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- sig_in  in  N_CH  monitored lines, one bit per channel; synchronous to clk.
- out_ready  in  1  consumer accepts the current event.
- out_valid  out  1  event available on out_ch/out_count.
- out_ch  out  CH_W  channel index of the presented event.
- out_count  out  CNT_W  that channel's event count including this event.
- pending  out  N_CH  per-channel event waiting to be issued.
- dropped  out  N_CH  sticky flag: an event was lost on that channel.

Behaviour:
- Reset: rst is sampled on posedge clk.
  - Clears sig_d, pending, dropped, all counters, out_valid, out_ch, out_count and rr_ptr to 0.
  - An event held on the output when rst asserts is discarded without handshake.
- Edge detect:
  - sig_d[i] <= sig_in[i] each cycle; fall[i] = sig_d[i] & ~sig_in[i] (combinational).
  - sig_d resets to 0, so a line that is low out of reset produces no event.
  - A line high at reset fires only after it is sampled high and then low.
- Pending:
  - pending[i] is set at the posedge where fall[i]=1.
  - It clears at the posedge where channel i is loaded into the output register.
  - fall[i] in the same cycle channel i is loaded: pending[i] stays 1 (new event queued).
  - fall[i] while pending[i]=1 and channel i is not being loaded that cycle: event is lost and dropped[i] <= 1.
  - dropped[i] stays set until rst.
- Output register (load condition):
  - Loads when (!out_valid | out_ready) and at least one pending bit is set.
  - Winner = first set pending bit searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH.
  - On load: out_valid <= 1, out_ch <= winner, cnt[winner] <= cnt[winner]+1 (wraps at 2^CNT_W-1 to 0), out_count <= new cnt[winner], rr_ptr <= (winner+1) mod N_CH.
- Output register (idle and hold):
  - No load while out_valid & out_ready: out_valid <= 0; out_ch/out_count hold their last values.
  - out_valid & !out_ready: out_valid, out_ch and out_count remain stable.
  - No counter changes while the output is stalled.
- Throughput and latency:
  - Back-to-back: one event per cycle while out_ready=1 and events are pending.
  - Minimum latency: sig_in sampled low at posedge t1 (high at t0) gives pending=1 after t1 and out_valid=1 after t2.
- Counters are modified only on load, never by fall directly.

Test Plan:
- Reset with sig_in=4'b0000, then drive sig_in[2] 1 then 0 (one cycle each), out_ready=1 -> out_valid pulses 1 cycle with out_ch=2, out_count=1; pending=0 and dropped=0 afterwards.
- Release rst with sig_in=4'b1111, then drop all four lines in the same cycle, out_ready=1 -> four consecutive valid cycles with out_ch=0,1,2,3 and out_count=1 each; rr_ptr ends at 0.
- Hold out_ready=0 with channel 1 presented, and make two more falling edges on channel 1 -> out_ch=1/out_count=1 held stable; pending[1]=1 after the first extra edge; dropped[1]=1 after the second; after out_ready=1, next event is ch1 with count=2.
- CNT_W=8: generate 256 accepted events on channel 3 -> out_count sequence 1..255 then 0 on the 256th; no other counter changes.
- Fairness: channels 0 and 1 re-toggling continuously, out_ready=1 -> grants alternate 0,1,0,1; neither channel is issued twice in a row while the other is pending.
- Assert rst while out_valid=1, out_ready=0 and pending=4'b1010 -> next cycle out_valid=0, pending=0, dropped=0, counters 0; first post-reset event reports out_count=1.
